// File: rtl/dfp_line_mem_if.sv
// dfp_line_mem_if: line-granular dfp request/response bundle.
// The initiator (cache) uses the master modport; the memory uses the slave modport.
interface dfp_line_mem_if #(
    parameter int LINE_BITS = 256
);
    logic [31:0]          dfp_addr;
    logic                 dfp_read;
    logic                 dfp_write;
    logic [LINE_BITS-1:0] dfp_wdata;
    logic [LINE_BITS-1:0] dfp_rdata;
    logic                 dfp_resp;

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp
    );

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp
    );
endinterface

// File: rtl/dfp_line_mem.sv
// dfp_line_mem: fixed-latency line memory responder for the cache dfp port.
// Define DFP_MEM_CHECK_EN to compile in the sticky protocol checker driving err.
module dfp_line_mem #(
    parameter int LINE_BITS   = 256,
    parameter int DEPTH_LINES = 64,
    parameter int LATENCY     = 4
) (
    input  logic          clk,
    input  logic          rst,
    dfp_line_mem_if.slave dfp,
    output logic          err
);
    localparam int IW = $clog2(DEPTH_LINES);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [LINE_BITS-1:0] mem [DEPTH_LINES];

    logic [1:0]           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 wr_q, wr_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic [LINE_BITS-1:0] rdata_q, rdata_d;
    logic                 resp_q, resp_d;
    logic                 req;
    logic                 done;

    assign req  = dfp.dfp_read || dfp.dfp_write;
    assign done = (state_q == BUSY) && (cnt_q == 8'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        resp_d  = done;
        rdata_d = (done && !wr_q) ? mem[idx_q] : '0;
        if (state_q == IDLE) begin
            if (req) begin
                state_d = BUSY;
                cnt_d   = 8'(LATENCY - 1);
                idx_d   = dfp.dfp_addr[5 +: IW];
                wr_d    = dfp.dfp_write;
                wdata_d = dfp.dfp_wdata;
            end
        end else if (state_q == BUSY) begin
            state_d = done ? RESP : BUSY;
            cnt_d   = done ? cnt_q : cnt_q - 8'd1;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
        end
    end

    // The array has no reset; the commit is gated by reset-cleared state.
    always_ff @(posedge clk) begin
        if (done && wr_q)
            mem[idx_q] <= wdata_q;
    end

    assign dfp.dfp_rdata = rdata_q;
    assign dfp.dfp_resp  = resp_q;

`ifdef DFP_MEM_CHECK_EN
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;

    always_comb begin
        addr_d = (state_q == IDLE && req) ? dfp.dfp_addr : addr_q;
        err_d  = err_q
              || (state_q == IDLE && req && ((dfp.dfp_read && dfp.dfp_write) || dfp.dfp_addr[4:0] != 5'd0))
              || (state_q == BUSY && (!req || dfp.dfp_addr != addr_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_addr;
    assign unused_addr = ^{dfp.dfp_addr[31:5+IW], dfp.dfp_addr[4:0]};
    assign err = 1'b0;
`endif
endmodule

// File: doc/dfp_line_mem.md
# dfp_line_mem

Synthesizable line-granular memory responder for the cache's downward-facing port (dfp). It is the far end of the dfp read/write/resp handshake: it accepts one 256-bit line request at a time, waits a fixed programmable latency, then commits the write or returns read data with a one-cycle `dfp_resp` pulse. It replaces the behavioural memory model in cache benches and provides a deterministic backing store for FPGA bring-up.

## Interface
- `LINE_BITS`, 256, line width in bits; fixed at 256 (32-byte lines, offset = addr[4:0]).
- `DEPTH_LINES`, 64, number of lines stored; power of two, ≥2.
- `LATENCY`, 4, cycles from request acceptance to `dfp_resp`; legal range 1..255.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-low.
- `dfp_addr`  input  32  line address; bits [4:0] ignored; index = addr[5 +: log2(DEPTH_LINES)]; upper bits ignored, so addresses alias modulo the depth.
- `dfp_read`  input  1  read request; held high by the initiator until `dfp_resp`.
- `dfp_write`  input  1  write request; held high by the initiator until `dfp_resp`.
- `dfp_wdata`  input  256  write line; sampled at acceptance.
- `dfp_rdata`  output  256  read line; valid only while `dfp_resp` is high.
- `dfp_resp`  output  1  one-cycle completion pulse.
- `err`  output  1  sticky protocol-error flag (see Configuration).

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: on a rising edge with `dfp_read | dfp_write`, latch index, op and `dfp_wdata`; load counter with `LATENCY-1`; go to BUSY. If both are high, the write wins and is served.
- BUSY: decrement counter each edge; when it is 0, go to RESP. On entering RESP: for a read, load `dfp_rdata` from the array; for a write, commit the latched line to the array.
- RESP: `dfp_resp`=1 for exactly one cycle; on the next edge go to IDLE, clear `dfp_resp`, and zero `dfp_rdata`.
- IDLE never accepts in the same cycle that `dfp_resp` is high. The minimum back-to-back period is `LATENCY+2` cycles per request.
- Request inputs are ignored in BUSY and RESP. Changes to the address or data after acceptance have no effect.
- The array is not cleared by reset. Contents are undefined until written. There are no partial-line writes.

## Timing
- Reset asserted (`rst`=0), asynchronously: state IDLE, counter 0, `dfp_resp`=0, `dfp_rdata`=0, `err`=0. Any in-flight write is dropped with no array update.
- Accept at edge T. `dfp_resp` and `dfp_rdata` are high/valid from edge T+LATENCY to edge T+LATENCY+1.
- A write is visible to a read accepted at or after edge T+LATENCY+1.
- With `LATENCY`=1, BUSY lasts one cycle: accept at T, resp at T+1.
- Outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `DFP_MEM_CHECK_EN` defined: the protocol checker is compiled in. `err` sets and stays set until reset on any of these events:
  - `dfp_read` and `dfp_write` both high when the request is accepted;
  - `dfp_addr[4:0]` ≠ 0 when the request is accepted;
  - the request deasserts, or `dfp_addr` changes, while the responder is in BUSY.
  The request is still serviced exactly as described in Operation.
- `DFP_MEM_CHECK_EN` not defined: the checker logic is absent and `err` is tied to 0. Functional behaviour is otherwise identical.

## Test plan
- Reset, `LATENCY`=4: write line 0x20 with all bytes = 0xA5 accepted at T → `dfp_resp` only during cycle T+4; then read 0x20 → `dfp_rdata` = {32{8'hA5}} with resp at accept+4; `dfp_rdata` = 0 outside resp.
- Aliasing with `DEPTH_LINES`=64: write 0x000 with pattern P, then read 0x800 → returns P.
- Back-to-back: hold `dfp_read` high through `dfp_resp` and keep it asserted → second acceptance occurs on the edge after resp drops, giving a period of `LATENCY+2`.
- Simultaneous `dfp_read` and `dfp_write` to 0x40 with wdata Q → Q is written; the following read returns Q; `err`=1 with `DFP_MEM_CHECK_EN`, `err`=0 without it.
- Reset mid-operation: write 0x60 with Q2 over prior content Q1; pull `rst` low at accept+2 → `dfp_resp` never pulses; after reset, a read of 0x60 returns Q1.
- `LATENCY`=1, misaligned address 0x64 with `DFP_MEM_CHECK_EN` → serviced as line 0x60 with resp at accept+1, and `err` rises.
